// File: rtl/cpu_rv32i_mc_ctrl.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXECUTE/MEM/WB/HALT sequencer driving datapath strobes.
// Optional bus timeout (MEM -> HALT with sticky busErr) is built only when MC_BUS_TIMEOUT_EN is defined.
module cpu_rv32i_mc_ctrl #(
  parameter int IMEM_LATENCY = 0,
  parameter int BUS_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  input  logic        busReady,
  output logic        irEn,
  output logic        pcEn,
  output logic        regFileWe,
  output logic        aluSrcMuxSel,
  output logic [3:0]  aluControl,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        busReq,
  output logic        busWe,
  output logic        illegalInstr,
  output logic        busErr
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;

  localparam logic [2:0] FETCH_LAST = 3'(IMEM_LATENCY);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEM,
    WB,
    HALT
  } stateT;

  stateT       state;
  stateT       nextState;
  logic [31:0] instrReg;
  logic [2:0]  fetchCnt;
  logic        fetchDone;
  logic        memTimeout;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        isR;
  logic        isI;
  logic        isLui;
  logic        isAuipc;
  logic        isJal;
  logic        isJalr;
  logic        isB;
  logic        isL;
  logic        isS;
  logic        isIllegal;
  logic        writesRd;
  logic        unusedIrBits;

  assign opcode       = instrReg[6:0];
  assign funct3       = instrReg[14:12];
  assign funct7b5     = instrReg[30];
  assign unusedIrBits = ^{instrReg[31], instrReg[29:15], instrReg[11:7]};

  assign fetchDone = (fetchCnt == FETCH_LAST);
  assign writesRd  = isR | isI | isLui | isAuipc | isJal | isJalr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instrReg <= '0;
    end else if (irEn) begin
      instrReg <= instrCode;
    end
  end

  // The wait counter only runs while sitting in FETCH, so it is zero whenever FETCH is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetchCnt <= '0;
    end else if ((state == FETCH) && !fetchDone) begin
      fetchCnt <= fetchCnt + 3'd1;
    end else begin
      fetchCnt <= '0;
    end
  end

`ifdef MC_BUS_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(BUS_TIMEOUT - 1);

  logic [7:0] memCnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memCnt <= '0;
    end else if ((state == MEM) && !busReady) begin
      memCnt <= memCnt + 8'd1;
    end else begin
      memCnt <= '0;
    end
  end

  assign memTimeout = (state == MEM) && !busReady && (memCnt == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busErr <= 1'b0;
    end else if (memTimeout) begin
      busErr <= 1'b1;
    end
  end
`else
  logic unusedTimeoutCfg;

  assign unusedTimeoutCfg = (BUS_TIMEOUT > 0);
  assign memTimeout       = 1'b0;
  assign busErr           = 1'b0;
`endif

  always_comb begin
    isR       = 1'b0;
    isI       = 1'b0;
    isLui     = 1'b0;
    isAuipc   = 1'b0;
    isJal     = 1'b0;
    isJalr    = 1'b0;
    isB       = 1'b0;
    isL       = 1'b0;
    isS       = 1'b0;
    isIllegal = 1'b0;
    case (opcode)
      OP_R:     isR       = 1'b1;
      OP_I:     isI       = 1'b1;
      OP_LUI:   isLui     = 1'b1;
      OP_AUIPC: isAuipc   = 1'b1;
      OP_JAL:   isJal     = 1'b1;
      OP_JALR:  isJalr    = 1'b1;
      OP_B:     isB       = 1'b1;
      OP_L:     isL       = 1'b1;
      OP_S:     isS       = 1'b1;
      default:  isIllegal = 1'b1;
    endcase
  end

  // Datapath selects depend only on the latched instruction; the FSM gates the enables.
  always_comb begin
    aluControl    = 4'b0000;
    aluSrcMuxSel  = 1'b0;
    RFWDSrcMuxSel = 3'd0;
    if (isR) begin
      aluControl = {funct7b5, funct3};
    end else if (isI) begin
      aluControl = {(funct3 == 3'b101) ? funct7b5 : 1'b0, funct3};
    end else if (isB) begin
      aluControl = {1'b0, funct3};
    end
    if (isI || isL || isS || isJalr) begin
      aluSrcMuxSel = 1'b1;
    end
    if (isL) begin
      RFWDSrcMuxSel = 3'd1;
    end else if (isLui) begin
      RFWDSrcMuxSel = 3'd2;
    end else if (isAuipc) begin
      RFWDSrcMuxSel = 3'd3;
    end else if (isJal || isJalr) begin
      RFWDSrcMuxSel = 3'd4;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      FETCH: begin
        if (fetchDone) begin
          nextState = DECODE;
        end
      end
      DECODE: begin
        nextState = EXECUTE;
      end
      EXECUTE: begin
        nextState = (isL || isS) ? MEM : FETCH;
      end
      MEM: begin
        if (busReady) begin
          nextState = isS ? FETCH : WB;
        end else if (memTimeout) begin
          nextState = HALT;
        end
      end
      WB: begin
        nextState = FETCH;
      end
      HALT: begin
        nextState = HALT;
      end
      default: begin
        nextState = FETCH;
      end
    endcase
  end

  always_comb begin
    irEn         = 1'b0;
    pcEn         = 1'b0;
    regFileWe    = 1'b0;
    branch       = 1'b0;
    jal          = 1'b0;
    jalr         = 1'b0;
    busReq       = 1'b0;
    busWe        = 1'b0;
    illegalInstr = 1'b0;
    case (state)
      FETCH: begin
        irEn = fetchDone;
      end
      EXECUTE: begin
        regFileWe    = writesRd;
        pcEn         = !(isL || isS);
        branch       = isB;
        jal          = isJal;
        jalr         = isJalr;
        illegalInstr = isIllegal;
      end
      MEM: begin
        busReq = 1'b1;
        busWe  = isS;
        pcEn   = busReady && isS;
      end
      WB: begin
        regFileWe = 1'b1;
        pcEn      = 1'b1;
      end
      default: begin
        irEn = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/cpu_rv32i_mc_ctrl.md
CPU_RV32I_MC_CTRL -- requirements
Module: cpu_rv32i_mc_ctrl

Interface
REQ-001 SHALL have parameter IMEM_LATENCY, default 0, extra instruction-memory wait cycles in FETCH (0..7).
REQ-002 SHALL have parameter BUS_TIMEOUT, default 15, maximum MEM cycles without busReady before error (1..255).
REQ-003 SHALL have one clock and an asynchronous active-high reset, as the following two ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
REQ-004 SHALL have the following data and handshake ports:
- instrCode  in  32  instruction from instruction memory.
- busReady  in  1  data-bus transfer complete.
- irEn  out  1  latch instrCode into the instruction register.
- pcEn  out  1  PC update strobe.
REQ-005 SHALL have the following datapath control ports:
- regFileWe  out  1  register file write enable.
- aluSrcMuxSel  out  1  0 = rs2, 1 = immediate.
- aluControl  out  4  ALU operation.
- RFWDSrcMuxSel  out  3  write-back source.
- branch / jal / jalr  out  1 each  PC source qualifiers.
REQ-006 SHALL have the following bus and status ports:
- busReq  out  1  data-bus request.
- busWe  out  1  data-bus write.
- illegalInstr  out  1  one-cycle pulse on an unknown opcode.
- busErr  out  1  sticky bus timeout flag.

Function
REQ-007 SHALL implement the states FETCH, DECODE, EXECUTE, MEM, WB and HALT, with outputs decoded from the state and the latched instruction.
REQ-008 FETCH SHALL last IMEM_LATENCY+1 cycles, with irEn=1 only in the last cycle, then go to DECODE.
REQ-009 DECODE SHALL last 1 cycle with all enables 0, then go to EXECUTE.
REQ-010 In EXECUTE, for R, I-ALU, LUI, AUIPC, JAL and JALR, the block SHALL assert regFileWe=1 and pcEn=1, then go to FETCH.
REQ-011 In EXECUTE, for B (1100011), the block SHALL assert pcEn=1 and branch=1 with regFileWe=0, then go to FETCH.
REQ-012 In EXECUTE, for L (0000011) and S (0100011), the block SHALL go to MEM with no enables asserted.
REQ-013 In MEM, busReq SHALL be 1 and busWe SHALL equal (opcode==S); the block SHALL hold MEM until it samples busReady=1.
REQ-014 On busReady=1 in MEM, an S instruction SHALL assert pcEn=1 and go to FETCH, and an L instruction SHALL go to WB.
REQ-015 WB SHALL assert regFileWe=1 and pcEn=1 for 1 cycle, then go to FETCH.
REQ-016 aluControl SHALL be:
- R: {funct7[5], funct3}.
- I-ALU: {funct3==101 ? funct7[5] : 0, funct3}.
- B: {0, funct3}.
- L, S, JAL, JALR, LUI, AUIPC: 0000.
REQ-017 aluSrcMuxSel SHALL be 1 for I-ALU, L, S and JALR, and 0 otherwise.
REQ-018 RFWDSrcMuxSel SHALL be 0 = ALU, 1 = busRData (L), 2 = immediate (LUI), 3 = PC+imm (AUIPC), 4 = PC+4 (JAL/JALR).
REQ-019 jal and jalr SHALL be 1 in EXECUTE only, for their respective opcodes.
REQ-020 An unknown opcode SHALL pulse illegalInstr for 1 cycle in EXECUTE with pcEn=1 and regFileWe=0, then go to FETCH.
REQ-021 busReady sampled outside MEM SHALL be ignored.
REQ-022 A FETCH wait counter of 3 bits and a MEM timeout counter of 8 bits SHALL be used, and each SHALL clear on state entry.
REQ-023 HALT SHALL drive all enables and busReq to 0 and SHALL be left only by reset.

Reset
REQ-024 On reset, the state SHALL be FETCH with counters 0, busErr 0, illegalInstr 0 and the instruction register 0.
REQ-025 Assertion of reset SHALL drop busReq, busWe and regFileWe asynchronously, including mid-MEM.
REQ-026 After reset deasserts, the first irEn SHALL occur IMEM_LATENCY cycles after the first clock edge.

Configuration
REQ-027 The macro MC_BUS_TIMEOUT_EN SHALL control the bus timeout feature.
- Defined: if busReady stays 0 for BUS_TIMEOUT consecutive MEM cycles, busErr SHALL set on the next edge and the state SHALL go to HALT.
- Not defined: MEM SHALL wait indefinitely, busErr SHALL be tied to 0, and HALT SHALL be unreachable.

Verification
REQ-028 With IMEM_LATENCY=0, the bench SHALL run ADD x3,x1,x2 (0x002081B3) -> irEn in cycle 1, then regFileWe=1, pcEn=1, aluControl=0000, RFWDSrcMuxSel=0 in cycle 3.
REQ-029 The bench SHALL run SW (0x0020A223) with busReady delayed 4 cycles -> busReq=1, busWe=1 for 5 cycles, pcEn on the busReady cycle, and no regFileWe.
REQ-030 The bench SHALL run LW (0x0000A183) with busReady immediate -> MEM 1 cycle, then WB with regFileWe=1 and RFWDSrcMuxSel=1.
REQ-031 The bench SHALL run opcode 0x0000007F -> illegalInstr pulse of 1 cycle and return to FETCH.
REQ-032 With MC_BUS_TIMEOUT_EN and BUS_TIMEOUT=3, the bench SHALL run LW with busReady held at 0 -> busErr=1 after 3 MEM cycles, then HALT with all enables 0 until reset.
REQ-033 With IMEM_LATENCY=2, the bench SHALL assert reset mid-MEM -> busReq=0 immediately, then irEn in the 3rd cycle after release.
